// File: rtl/jamia_pkg.sv
// rtl/jamia_pkg.sv - shared fetch/machine-control types and constants
package jamia_pkg;

  localparam logic [1:0] PC_BOOT = 2'b00;
  localparam logic [1:0] PC_NEXT = 2'b01;
  localparam logic [1:0] PC_TRAP = 2'b10;
  localparam logic [1:0] PC_EPC  = 2'b11;

  typedef enum logic [2:0] {
    IF_IDLE  = 3'd0,
    IF_REQ   = 3'd1,
    IF_WAIT  = 3'd2,
    IF_HOLD  = 3'd3,
    IF_MISAL = 3'd4
  } fetch_state_t;

  localparam logic [3:0] CAUSE_MISALIGNED_FETCH = 4'd0;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - redirect target mux with flush > branch priority and alignment check
module pc_next_sel
  import jamia_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR = '0
) (
  input  logic            i_flush,
  input  logic [1:0]      i_pc_src,
  input  logic [XLEN-1:0] i_trap_addr,
  input  logic [XLEN-1:0] i_epc,
  input  logic            i_branch_taken,
  input  logic [XLEN-1:0] i_branch_target,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_target,
  output logic            o_misaligned,
  output logic [XLEN-1:0] o_seq_pc
);

  always_comb begin
    o_seq_pc   = i_pc + XLEN'(4);
    o_target   = o_seq_pc;
    o_redirect = i_flush | i_branch_taken;
    if (i_flush) begin
      case (i_pc_src)
        PC_BOOT: o_target = BOOT_ADDR;
        PC_NEXT: o_target = o_seq_pc;
        PC_TRAP: o_target = i_trap_addr;
        PC_EPC:  o_target = i_epc;
      endcase
    end else if (i_branch_taken) begin
      o_target = i_branch_target;
    end
    o_misaligned = o_redirect && is_misaligned(o_target[1:0]);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding instruction fetch stage owning the PC
module instr_fetch_unit
  import jamia_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR = '0
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [1:0]      pc_src_in,
  input  logic            flush_in,
  input  logic [XLEN-1:0] trap_addr_in,
  input  logic [XLEN-1:0] epc_in,
  input  logic            branch_taken_in,
  input  logic [XLEN-1:0] branch_target_in,
  input  logic            stall_in,
  output logic            imem_req_out,
  output logic [XLEN-1:0] imem_addr_out,
  input  logic            imem_gnt_in,
  input  logic            imem_rvalid_in,
  input  logic [XLEN-1:0] imem_rdata_in,
  output logic            instr_valid_out,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic            misaligned_instr_out
);

  fetch_state_t    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [XLEN-1:0] r_instr, w_instr_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_kill, w_kill_nxt;
  logic            r_misal, w_misal_nxt;

  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic            w_target_misal;
  logic [XLEN-1:0] w_seq_pc;
  logic            w_req;
  logic            w_in_flight;

  pc_next_sel #(.XLEN(XLEN), .BOOT_ADDR(BOOT_ADDR)) u_pc_next_sel (
    .i_flush         (flush_in),
    .i_pc_src        (pc_src_in),
    .i_trap_addr     (trap_addr_in),
    .i_epc           (epc_in),
    .i_branch_taken  (branch_taken_in),
    .i_branch_target (branch_target_in),
    .i_pc            (r_pc),
    .o_redirect      (w_redirect),
    .o_target        (w_target),
    .o_misaligned    (w_target_misal),
    .o_seq_pc        (w_seq_pc)
  );

  // While a killed response is still owed, the request line stays low.
  assign w_req       = (r_state == IF_REQ) && !r_kill;
  assign w_in_flight = ((r_state == IF_WAIT) && !imem_rvalid_in) ||
                       (w_req && imem_gnt_in);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_valid;
    w_misal_nxt = r_misal;
    w_kill_nxt  = r_kill && !imem_rvalid_in;
    if (w_redirect) begin
      w_pc_nxt    = w_target;
      w_valid_nxt = 1'b0;
      w_misal_nxt = w_target_misal;
      w_state_nxt = w_target_misal ? IF_MISAL : IF_REQ;
      if (w_in_flight) w_kill_nxt = 1'b1;
    end else begin
      case (r_state)
        IF_IDLE: w_state_nxt = IF_REQ;
        IF_REQ: begin
          if (w_req && imem_gnt_in) w_state_nxt = IF_WAIT;
        end
        IF_WAIT: begin
          if (imem_rvalid_in) begin
            w_instr_nxt = imem_rdata_in;
            w_valid_nxt = 1'b1;
            w_state_nxt = IF_HOLD;
          end
        end
        IF_HOLD: begin
          if (!stall_in) begin
            w_valid_nxt = 1'b0;
            w_pc_nxt    = w_seq_pc;
            w_state_nxt = IF_REQ;
          end
        end
        IF_MISAL: w_state_nxt = IF_MISAL;
        default:  w_state_nxt = IF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= IF_IDLE;
      r_pc    <= BOOT_ADDR;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_kill  <= 1'b0;
      r_misal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_valid <= w_valid_nxt;
      r_kill  <= w_kill_nxt;
      r_misal <= w_misal_nxt;
    end
  end

  assign imem_req_out         = w_req;
  assign imem_addr_out        = {r_pc[XLEN-1:2], 2'b00};
  assign instr_valid_out      = r_valid;
  assign instr_out            = r_instr;
  assign pc_out               = r_pc;
  assign misaligned_instr_out = r_misal;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized fetch-stage bench with program-order reference model
module tb_instr_fetch_unit;

  localparam logic [31:0] BOOT = 32'h0000_0000;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [1:0]  pc_src_in = 2'b00;
  logic        flush_in = 1'b0;
  logic [31:0] trap_addr_in = '0;
  logic [31:0] epc_in = '0;
  logic        branch_taken_in = 1'b0;
  logic [31:0] branch_target_in = '0;
  logic        stall_in = 1'b0;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in = 1'b0;
  logic        imem_rvalid_in = 1'b0;
  logic [31:0] imem_rdata_in = '0;
  logic        instr_valid_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        misaligned_instr_out;

  instr_fetch_unit #(.XLEN(32), .BOOT_ADDR(BOOT)) dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .pc_src_in            (pc_src_in),
    .flush_in             (flush_in),
    .trap_addr_in         (trap_addr_in),
    .epc_in               (epc_in),
    .branch_taken_in      (branch_taken_in),
    .branch_target_in     (branch_target_in),
    .stall_in             (stall_in),
    .imem_req_out         (imem_req_out),
    .imem_addr_out        (imem_addr_out),
    .imem_gnt_in          (imem_gnt_in),
    .imem_rvalid_in       (imem_rvalid_in),
    .imem_rdata_in        (imem_rdata_in),
    .instr_valid_out      (instr_valid_out),
    .instr_out            (instr_out),
    .pc_out               (pc_out),
    .misaligned_instr_out (misaligned_instr_out)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0000 ^ {a[15:0], a[31:16]} ^ 32'h0000_1357;
  endfunction

  // Reference model: program-order PC plus a single-slot memory.
  logic [31:0] exp_pc = BOOT;
  logic        exp_misal = 1'b0;
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_lat = 0;
  int          lat_mode = 0;
  bit          noise = 1'b0;
  bit          chk_period = 1'b0;
  bit          prev_valid = 1'b0;
  int          cyc = 0;
  int          last_valid = -1;
  int          n_valid = 0;

  task automatic step();
    logic        rsp, take;
    logic [31:0] tgt, gaddr;
    check("pc_out", pc_out, exp_pc);
    check("misaligned", misaligned_instr_out, exp_misal);
    check("addr_lsb", {30'b0, imem_addr_out[1:0]}, 32'h0);
    if (exp_misal) check("misal_noreq", imem_req_out, 1'b0);
    if (instr_valid_out) begin
      check("instr", instr_out, mem_word(exp_pc));
      check("valid_noreq", imem_req_out, 1'b0);
    end
    if (instr_valid_out && !prev_valid) begin
      n_valid++;
      if (chk_period && last_valid >= 0) check("period", cyc - last_valid, 3);
      last_valid = cyc;
    end
    prev_valid = instr_valid_out;

    rsp = 1'b0; take = 1'b0; gaddr = imem_addr_out;
    imem_gnt_in = 1'b0; imem_rvalid_in = 1'b0; imem_rdata_in = $urandom;
    if (mem_busy) begin
      if (mem_lat == 0) begin
        rsp = 1'b1; imem_rvalid_in = 1'b1; imem_rdata_in = mem_word(mem_addr);
      end else mem_lat--;
    end else if (noise) imem_rvalid_in = ($urandom_range(0, 7) == 0);
    if (imem_req_out) begin
      if (lat_mode == 0 || $urandom_range(0, 2) != 0) begin
        imem_gnt_in = 1'b1; take = 1'b1;
        check("one_outstanding", mem_busy && !rsp, 1'b0);
        check("req_addr", imem_addr_out, exp_pc);
      end
    end else if (noise) imem_gnt_in = ($urandom_range(0, 3) == 0);

    tgt = exp_pc + 32'd4;
    if (flush_in) begin
      case (pc_src_in)
        2'b00: tgt = BOOT;
        2'b01: tgt = exp_pc + 32'd4;
        2'b10: tgt = trap_addr_in;
        2'b11: tgt = epc_in;
      endcase
    end else if (branch_taken_in) tgt = branch_target_in;
    if (flush_in || branch_taken_in) begin
      exp_pc = tgt; exp_misal = (tgt[1:0] != 2'b00);
    end else if (instr_valid_out && !stall_in) exp_pc = exp_pc + 32'd4;

    @(posedge clk_in); #1;
    cyc++;
    if (rsp) mem_busy = 1'b0;
    if (take) begin
      mem_busy = 1'b1; mem_addr = gaddr;
      mem_lat = (lat_mode < 0) ? $urandom_range(0, 3) : ((lat_mode > 0) ? lat_mode : 0);
    end
    flush_in = 1'b0; branch_taken_in = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, imem_req_out, 1'b0);
    check({tag, "_addr"}, imem_addr_out, BOOT);
    check({tag, "_valid"}, instr_valid_out, 1'b0);
    check({tag, "_instr"}, instr_out, 32'h0);
    check({tag, "_pc"}, pc_out, BOOT);
    check({tag, "_misal"}, misaligned_instr_out, 1'b0);
  endtask

  logic [31:0] held_pc, rv;

  initial begin
    repeat (2) @(posedge clk_in);
    #1;
    check_reset_outputs("reset");
    rst_in = 1'b1;

    // 1: zero-wait sequential fetch from BOOT
    lat_mode = 0; chk_period = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check("t1_valid_count", (n_valid >= 3), 1'b1);
    chk_period = 1'b0;

    // 2: stall in HOLD for 5 cycles
    for (int i = 0; i < 20 && !instr_valid_out; i++) step();
    check("t2_valid_seen", instr_valid_out, 1'b1);
    held_pc = pc_out;
    stall_in = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("t2_held_pc", pc_out, held_pc);
    stall_in = 1'b0;
    for (int i = 0; i < 20 && !imem_req_out; i++) step();
    check("t2_next_req", imem_addr_out, held_pc + 32'd4);

    // 3: trap flush while a response is pending
    lat_mode = 2;
    for (int i = 0; i < 20 && !mem_busy; i++) step();
    check("t3_in_wait", mem_busy, 1'b1);
    flush_in = 1'b1; pc_src_in = 2'b10; trap_addr_in = 32'h100;
    step();
    check("t3_pc", pc_out, 32'h100);
    for (int i = 0; i < 20 && !imem_req_out; i++) step();
    check("t3_req_addr", imem_addr_out, 32'h100);
    for (int i = 0; i < 20 && !instr_valid_out; i++) step();
    check("t3_instr", instr_out, mem_word(32'h100));

    // 4: misaligned branch, then EPC return
    lat_mode = 0;
    branch_taken_in = 1'b1; branch_target_in = 32'h202;
    step();
    check("t4_misal", misaligned_instr_out, 1'b1);
    check("t4_pc", pc_out, 32'h202);
    for (int i = 0; i < 4; i++) step();
    flush_in = 1'b1; pc_src_in = 2'b11; epc_in = 32'h40;
    step();
    check("t4_misal_clr", misaligned_instr_out, 1'b0);
    for (int i = 0; i < 20 && !imem_req_out; i++) step();
    check("t4_req_addr", imem_addr_out, 32'h40);

    // 5: flush beats branch in the same cycle
    flush_in = 1'b1; pc_src_in = 2'b00; branch_taken_in = 1'b1; branch_target_in = 32'h80;
    step();
    check("t5_pc", pc_out, BOOT);
    for (int i = 0; i < 20 && !imem_req_out; i++) step();
    check("t5_req_addr", imem_addr_out, BOOT);

    // 6: wrap at top of address space, then async reset in WAIT
    branch_taken_in = 1'b1; branch_target_in = 32'hFFFF_FFFC;
    step();
    for (int i = 0; i < 20 && !instr_valid_out; i++) step();
    check("t6_top_pc", pc_out, 32'hFFFF_FFFC);
    step();
    for (int i = 0; i < 20 && !imem_req_out; i++) step();
    check("t6_wrap_addr", imem_addr_out, 32'h0);
    lat_mode = 3;
    for (int i = 0; i < 20 && !(mem_busy && mem_lat >= 1); i++) step();
    check("t6_in_wait", mem_busy, 1'b1);
    #2 rst_in = 1'b0;
    #1 check_reset_outputs("async_rst");
    mem_busy = 1'b0; exp_pc = BOOT; exp_misal = 1'b0; prev_valid = 1'b0;
    imem_gnt_in = 1'b0; imem_rvalid_in = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b1;

    // Random phase
    lat_mode = -1; noise = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      stall_in = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 31) == 0) begin
        flush_in = 1'b1; pc_src_in = 2'($urandom_range(0, 3));
        rv = $urandom; trap_addr_in = {rv[31:2], ($urandom_range(0, 15) == 0) ? 2'b10 : 2'b00};
        rv = $urandom; epc_in = {rv[31:2], 2'b00};
      end
      if ($urandom_range(0, 31) == 0) begin
        branch_taken_in = 1'b1;
        rv = $urandom;
        branch_target_in = ($urandom_range(0, 7) == 0) ? rv :
                           (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : {rv[31:2], 2'b00});
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
